muldiv_unit: RTL

Multi-cycle integer multiply/divide unit downstream of the 32×32 register file: consumes the register file's S and T read ports and produces the 64-bit HI/LO result pair for MIPS MULT, MULTU, DIV and DIVU. It also supports MTHI and MTLO writes from S. A single FSM runs one shift-add or restoring-subtract iteration per clock. Control logic holds the pipeline while `busy` is high.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_unit_if.sv | 30 +++
 rtl/muldiv_step.sv | 33 +++
 rtl/muldiv_unit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: op encodings,
// FSM state encoding, iteration constants and a small absolute-value helper.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITERS = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } md_mode_e;

    // Magnitude of a two's-complement word; 0x80000000 maps to itself, which
    // is exactly the unsigned magnitude the datapath needs.
    function automatic logic [MD_WIDTH-1:0] md_abs(input logic [MD_WIDTH-1:0] v,
                                                   input logic                is_signed);
        return (is_signed && v[MD_WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Bundle of register-file operands, control and HI/LO results for muldiv_unit.
interface muldiv_unit_if;
    import muldiv_pkg::*;

    // start is sampled only while busy=0; a start seen while busy=1 is dropped,
    // not queued. done pulses for the single cycle in which HI/LO first show
    // the new result, and busy is already low in that cycle.
    logic                start;
    logic [1:0]          op;
    logic                mt_hi;
    logic                mt_lo;
    logic [MD_WIDTH-1:0] S;
    logic [MD_WIDTH-1:0] T;
    logic                busy;
    logic                done;
    logic [MD_WIDTH-1:0] HI;
    logic [MD_WIDTH-1:0] LO;
    logic [1:0]          dbg_state;

    modport master (
        output start, op, mt_hi, mt_lo, S, T,
        input  busy, done, HI, LO, dbg_state
    );

    modport slave (
        input  start, op, mt_hi, mt_lo, S, T,
        output busy, done, HI, LO, dbg_state
    );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of MSB-first shift-add multiply or restoring shift-subtract
// divide on a 64-bit accumulator.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [2*MD_WIDTH-1:0] i_acc,
    input  logic [MD_WIDTH-1:0]   i_operand,
    input  md_mode_e              i_mode,
    input  logic                  i_bit,
    output logic [2*MD_WIDTH-1:0] o_acc
);

    logic [MD_WIDTH:0]   w_rem;
    logic [MD_WIDTH-1:0] w_diff;

    // Divide keeps remainder in the upper half and shifts quotient bits into
    // the lower half; the remainder stays below the divisor, so the 32-bit
    // difference is exact whenever it is used.
    always_comb begin
        o_acc  = '0;
        w_rem  = {i_acc[2*MD_WIDTH-1:MD_WIDTH], i_bit};
        w_diff = w_rem[MD_WIDTH-1:0] - i_operand;
        if (i_mode == MODE_MUL) begin
            o_acc = {i_acc[2*MD_WIDTH-2:0], 1'b0}
                  + (i_bit ? {{MD_WIDTH{1'b0}}, i_operand} : {(2*MD_WIDTH){1'b0}});
        end else if (w_rem >= {1'b0, i_operand}) begin
            o_acc = {w_diff, i_acc[MD_WIDTH-2:0], 1'b1};
        end else begin
            o_acc = {w_rem[MD_WIDTH-1:0], i_acc[MD_WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: 32 iterations in CALC, sign fix-up in FIX,
// fixed 33-cycle latency, plus MTHI/MTLO writes while idle.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_FIX  = FIX;

    logic [1:0]            r_state;
    logic [4:0]            r_cnt;
    logic [1:0]            r_op;
    logic [2*MD_WIDTH-1:0] r_acc;
    logic [MD_WIDTH-1:0]   r_opnd;
    logic [MD_WIDTH-1:0]   r_shift;
    logic [MD_WIDTH-1:0]   r_s_orig;
    logic                  r_neg_res;
    logic                  r_neg_rem;
    logic                  r_div0;
    logic [MD_WIDTH-1:0]   r_hi;
    logic [MD_WIDTH-1:0]   r_lo;
    logic                  r_done;

    logic                  w_start_signed;
    logic [MD_WIDTH-1:0]   w_abs_s;
    logic [MD_WIDTH-1:0]   w_abs_t;
    md_mode_e              w_mode;
    logic [2*MD_WIDTH-1:0] w_step_acc;
    logic [2*MD_WIDTH-1:0] w_prod_fix;
    logic [MD_WIDTH-1:0]   w_quo_fix;
    logic [MD_WIDTH-1:0]   w_rem_fix;

    assign w_start_signed = ~bus.op[0];
    assign w_abs_s        = md_abs(bus.S, w_start_signed);
    assign w_abs_t        = md_abs(bus.T, w_start_signed);
    assign w_mode         = r_op[1] ? MODE_DIV : MODE_MUL;

    // r_shift feeds one bit per iteration: multiplier bits for multiply,
    // dividend bits for divide, both MSB first.
    muldiv_step u_step (
        .i_acc     (r_acc),
        .i_operand (r_opnd),
        .i_mode    (w_mode),
        .i_bit     (r_shift[MD_WIDTH-1]),
        .o_acc     (w_step_acc)
    );

    assign w_prod_fix = r_neg_res ? (~r_acc + 1'b1) : r_acc;
    assign w_quo_fix  = r_neg_res ? (~r_acc[MD_WIDTH-1:0] + 1'b1) : r_acc[MD_WIDTH-1:0];
    assign w_rem_fix  = r_neg_rem ? (~r_acc[2*MD_WIDTH-1:MD_WIDTH] + 1'b1)
                                  : r_acc[2*MD_WIDTH-1:MD_WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_shift   <= '0;
            r_s_orig  <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state   <= ST_CALC;
                        r_op      <= bus.op;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_s_orig  <= bus.S;
                        r_div0    <= bus.op[1] && (bus.T == '0);
                        r_neg_res <= w_start_signed && (bus.S[MD_WIDTH-1] ^ bus.T[MD_WIDTH-1]);
                        r_neg_rem <= w_start_signed && bus.S[MD_WIDTH-1];
                        if (bus.op[1]) begin
                            r_opnd  <= w_abs_t;
                            r_shift <= w_abs_s;
                        end else begin
                            r_opnd  <= w_abs_s;
                            r_shift <= w_abs_t;
                        end
                    end else begin
                        if (bus.mt_hi) r_hi <= bus.S;
                        if (bus.mt_lo) r_lo <= bus.S;
                    end
                end
                ST_CALC: begin
                    r_acc   <= w_step_acc;
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt + 5'd1;
                    if (r_cnt == 5'(MD_ITERS - 1)) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                    if (!r_op[1]) begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end else if (r_div0) begin
                        r_hi <= r_s_orig;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;
    assign bus.HI        = r_hi;
    assign bus.LO        = r_lo;
    assign bus.dbg_state = r_state;

endmodule
